// File: rtl/lbist_misr_engine_if.sv
// Pattern/response handshake between the LBIST engine (master side) and the
// core under test (slave side).
interface lbist_misr_engine_if #(
  parameter int PAT_W = 32,
  parameter int RSP_W = 32,
  parameter int NCH   = 2
);

  logic                 dut_restart;  // one-cycle pulse: core restarts from its reset PC
  logic                 pat_valid;    // one-cycle strobe: pattern is valid
  logic [PAT_W-1:0]     pattern;      // held from pat_valid until the response is accepted
  logic                 rsp_valid;    // core response ready (end of instruction)
  logic [NCH*RSP_W-1:0] rsp_data;     // channel k at bits [k*RSP_W +: RSP_W]

  modport master (
    output dut_restart, pat_valid, pattern,
    input  rsp_valid, rsp_data
  );

  modport slave (
    input  dut_restart, pat_valid, pattern,
    output rsp_valid, rsp_data
  );

endinterface

// File: rtl/lbist_misr_engine.sv
// LBIST engine: controller FSM, Galois-LFSR pattern generator and NCH-channel
// MISR response compactor. Each run restarts the core, applies NUM_PAT
// patterns, folds every response into the MISR and compares the final
// signature with golden_sig.
// Optional response watchdog: define LBIST_TIMEOUT_EN to abort a run that
// waits TIMEOUT cycles for a response (timeout flag set, P_F forced to 0).
module lbist_misr_engine #(
  parameter int          PAT_W     = 32,
  parameter int          RSP_W     = 32,
  parameter int          NCH       = 2,
  parameter int          NUM_PAT   = 256,
  parameter logic [31:0] SEED      = 32'h0000_0001,
  parameter logic [31:0] LFSR_POLY = 32'h8020_0003,
  parameter logic [31:0] MISR_POLY = 32'h04C1_1DB7,
  parameter int          TIMEOUT   = 1024
) (
  input  logic                       clk,
  input  logic                       Rst,
  input  logic                       test_start,
  lbist_misr_engine_if.master        bus,
  input  logic [RSP_W-1:0]           golden_sig,
  output logic                       busy,
  output logic                       test_done,
  output logic                       P_F,
  output logic [RSP_W-1:0]           signature,
  output logic                       timeout
);

  localparam int CNT_W = $clog2(NUM_PAT + 1);

  // Parameters wider than the datapath keep only their low bits.
  localparam logic [PAT_W-1:0] LFSR_TAPS = PAT_W'(LFSR_POLY);
  localparam logic [RSP_W-1:0] MISR_TAPS = RSP_W'(MISR_POLY);
  localparam logic [PAT_W-1:0] SEED_RAW  = PAT_W'(SEED);
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [PAT_W-1:0] SEED_V    = (SEED_RAW == '0) ? PAT_W'(1) : SEED_RAW;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RESTART = 3'd1;
  localparam logic [2:0] S_APPLY   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_COMPARE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  // Reject parameter sets the datapath cannot represent.
  if (PAT_W < 2 || RSP_W < 2 || NCH < 1 || NUM_PAT < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("lbist_misr_engine: illegal parameter set");
  end

  logic [2:0]       state_q, state_d;
  logic [PAT_W-1:0] lfsr_q, lfsr_d;
  logic [RSP_W-1:0] misr_q, misr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pf_q, pf_d;
  logic [RSP_W-1:0] fold;
  logic             last_pat;

`ifdef LBIST_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic             tmo_q, tmo_d;
`endif

  assign last_pat = (cnt_q == CNT_W'(NUM_PAT - 1));

  // XOR-fold all response channels into one MISR input word.
  always_comb begin
    fold = '0;
    for (int k = 0; k < NCH; k++) begin
      fold = fold ^ bus.rsp_data[k*RSP_W +: RSP_W];
    end
  end

  // Next-state, LFSR/MISR update and verdict logic.
  always_comb begin
    // NOTE: every *_d gets its hold value first so no path through the case infers a latch.
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    pf_d    = pf_q;
`ifdef LBIST_TIMEOUT_EN
    wdog_d  = wdog_q;
    tmo_d   = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (test_start) state_d = S_RESTART;
      end
      S_RESTART: begin
        lfsr_d  = SEED_V;
        misr_d  = '0;
        cnt_d   = '0;
        pf_d    = 1'b0;
`ifdef LBIST_TIMEOUT_EN
        wdog_d  = '0;
        tmo_d   = 1'b0;
`endif
        state_d = S_APPLY;
      end
      S_APPLY: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.rsp_valid) begin
          misr_d  = {misr_q[RSP_W-2:0], 1'b0} ^ (misr_q[RSP_W-1] ? MISR_TAPS : '0) ^ fold;
          lfsr_d  = {lfsr_q[PAT_W-2:0], 1'b0} ^ (lfsr_q[PAT_W-1] ? LFSR_TAPS : '0);
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = last_pat ? S_COMPARE : S_APPLY;
`ifdef LBIST_TIMEOUT_EN
          wdog_d  = '0;
        end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          pf_d    = 1'b0;
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wdog_d  = wdog_q + WD_W'(1);
`endif
        end
      end
      S_COMPARE: begin
        pf_d    = (misr_q == golden_sig);
        state_d = S_DONE;
      end
      S_DONE: begin
        // Wait for start to drop so a held-high request cannot retrigger.
        if (!test_start) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any run in progress.
  always_ff @(posedge clk or posedge Rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (Rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED_V;
      misr_q  <= '0;
      cnt_q   <= '0;
      pf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
      pf_q    <= pf_d;
    end
  end

`ifdef LBIST_TIMEOUT_EN
  // Watchdog registers.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      wdog_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      tmo_q  <= tmo_d;
    end
  end

  assign timeout = tmo_q;
`else
  assign timeout = 1'b0;
`endif

  assign bus.dut_restart = (state_q == S_RESTART);
  assign bus.pat_valid   = (state_q == S_APPLY);
  assign bus.pattern     = lfsr_q;
  assign busy            = (state_q != S_IDLE) && (state_q != S_DONE);
  assign test_done       = (state_q == S_DONE);
  assign P_F             = pf_q;
  assign signature       = misr_q;

endmodule
